// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills a prefetch queue from imem, drains to decode via valid/ready.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets enter FAULT instead of being forced word-aligned.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 400,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

  typedef enum logic {RUN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t          state;
  logic [31:0]     pc;
  entry_t          q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            in_range;
  logic            pop;
  logic            push;
  logic            range_fault;
  logic [PW-1:0]   rd_next;
  logic [CW-1:0]   count_next;
  entry_t          new_entry;
  entry_t          head_next;
  logic [31:0]     load_pc;
  logic            align_fault;

  assign imem_addr = pc;

  always_comb begin
    // 33-bit sum so a PC near 2^32 cannot wrap back into range
    in_range    = ({1'b0, pc} + 33'd3) <= LAST_BYTE;
    pop         = inst_valid & inst_ready;
    push        = (state == RUN) && fetch_en && !redirect_valid && in_range &&
                  ((count != CW'(DEPTH)) || pop);
    range_fault = (state == RUN) && fetch_en && !redirect_valid && !in_range;
    rd_next     = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next  = count + CW'(push) - CW'(pop);
    new_entry   = entry_t'({pc, imem_data});
    // Registered head must see a word being written into the slot it is about to point at
    head_next   = (push && (wr_ptr == rd_next)) ? new_entry : q[rd_next];
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign load_pc     = redirect_pc;
  assign align_fault = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_align;
  assign unused_align = ^redirect_pc[1:0];
  assign load_pc      = {redirect_pc[31:2], 2'b00};
  assign align_fault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      fault      <= 1'b0;
      fault_pc   <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (redirect_valid) begin
      pc         <= load_pc;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      if (align_fault) begin
        state    <= FAULT;
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
      end else begin
        state    <= RUN;
        fault    <= 1'b0;
        fault_pc <= '0;
      end
    end else begin
      if (push) begin
        q[wr_ptr] <= new_entry;
        wr_ptr    <= wr_ptr + 1'b1;
        pc        <= pc + 32'd4;
      end
      rd_ptr     <= rd_next;
      count      <= count_next;
      inst_valid <= (count_next != '0);
      inst_data  <= (count_next != '0) ? head_next.word : '0;
      inst_pc    <= (count_next != '0) ? head_next.pc : '0;
      if (range_fault) begin
        state    <= FAULT;
        fault    <= 1'b1;
        fault_pc <= pc;
      end
    end
  end

endmodule
